// File: rtl/status_reporter.sv
// Telemetry frame builder: SOF/STATUS/SEQ/CHK frames to UART TX on period, status change or host query.
// Define STATUS_REPORT_CRC_EN to replace the XOR checksum with CRC-8 (poly 0x07) over SOF, STATUS, SEQ.
module status_reporter #(
    parameter int unsigned PERIOD_CYCLES  = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [7:0]  QUERY_CHAR     = 8'h3F,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Light,
    input  logic       Sensor,
    input  logic       Beeper,
    input  logic       lightSwitch,
    input  logic       finalcarrera1,
    input  logic       finalcarrera2,
    input  logic       motor1,
    input  logic       motor2,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    output logic [7:0] TxData,
    output logic       TxStart,
    input  logic       TxDone,
    output logic       Busy,
    output logic       TimeoutErr
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;

    state_t      state;
    logic [7:0]  rawStatus, syncMeta, syncStatus;
    logic [7:0]  seq, lastSent, snap, chk, loadChk, nextByte;
    logic [1:0]  idx;
    logic        pending;
    logic [31:0] periodCnt, timeoutCnt;
    logic        periodHit, queryHit, changeHit, startFrame, timeoutHit;

    assign rawStatus = {motor2, motor1, finalcarrera2, finalcarrera1,
                        lightSwitch, Beeper, Sensor, Light};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            syncMeta   <= '0;
            syncStatus <= '0;
        end else begin
            syncMeta   <= rawStatus;
            syncStatus <= syncMeta;
        end
    end

    assign periodHit  = (PERIOD_CYCLES != 0) && (periodCnt == PERIOD_CYCLES - 1);
    assign queryHit   = RxDone && (RxData == QUERY_CHAR);
    assign changeHit  = syncStatus != lastSent;
    assign startFrame = (state == IDLE) && (periodHit || queryHit || changeHit || pending);
    assign timeoutHit = timeoutCnt == TIMEOUT_CYCLES - 1;

`ifdef STATUS_REPORT_CRC_EN
    function automatic logic [7:0] crc8(input logic [23:0] data);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign loadChk = crc8({SOF_BYTE, syncStatus, seq});
`else
    assign loadChk = SOF_BYTE ^ syncStatus ^ seq;
`endif

    // Byte that follows the one just acknowledged
    always_comb begin
        nextByte = chk;
        case (idx)
            2'd0:    nextByte = snap;
            2'd1:    nextByte = seq;
            default: nextByte = chk;
        endcase
    end

    // Free-running, restarted at each frame start so periodic frames stay evenly spaced
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                      periodCnt <= '0;
        else if (startFrame || periodHit) periodCnt <= '0;
        else                             periodCnt <= periodCnt + 32'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            TxData     <= '0;
            TxStart    <= 1'b0;
            Busy       <= 1'b0;
            TimeoutErr <= 1'b0;
            seq        <= '0;
            lastSent   <= '0;
            snap       <= '0;
            chk        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            timeoutCnt <= '0;
        end else begin
            TxStart    <= 1'b0;
            TimeoutErr <= 1'b0;
            if (state != IDLE && (periodHit || queryHit)) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (startFrame) begin
                        pending <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    snap    <= syncStatus;
                    chk     <= loadChk;
                    idx     <= '0;
                    Busy    <= 1'b1;
                    TxStart <= 1'b1;
                    TxData  <= SOF_BYTE;
                    state   <= SEND;
                end
                SEND: begin
                    timeoutCnt <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (TxDone) begin
                        if (idx == 2'd3) begin
                            seq      <= seq + 8'd1;
                            lastSent <= snap;
                            Busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx     <= idx + 2'd1;
                            TxStart <= 1'b1;
                            TxData  <= nextByte;
                            state   <= SEND;
                        end
                    end else if (timeoutHit) begin
                        TimeoutErr <= 1'b1;
                        Busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_status_reporter.sv
// Scoreboard bench for status_reporter: directed frames on one instance, periodic/SEQ-wrap on a second.
module tb_status_reporter;
`ifdef STATUS_REPORT_CRC_EN
    localparam bit CrcOn = 1'b1;
`else
    localparam bit CrcOn = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n, pRst_n;
    logic [7:0] status, RxData;
    logic       RxDone, TxDone, pTxDone, pPrev;
    logic [7:0] TxData, pTxData;
    logic       TxStart, Busy, TimeoutErr, pTxStart, pBusy, pTimeoutErr;

    int checks = 0, errors = 0, cyc = 0, doneBudget = 1000000;
    logic [7:0] expQ[$];
    logic [7:0] pExpQ[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    status_reporter #(.PERIOD_CYCLES(0), .TIMEOUT_CYCLES(50)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Light(status[0]), .Sensor(status[1]), .Beeper(status[2]), .lightSwitch(status[3]),
        .finalcarrera1(status[4]), .finalcarrera2(status[5]), .motor1(status[6]), .motor2(status[7]),
        .RxData(RxData), .RxDone(RxDone), .TxData(TxData), .TxStart(TxStart), .TxDone(TxDone),
        .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    status_reporter #(.PERIOD_CYCLES(100), .TIMEOUT_CYCLES(50)) pdut (
        .Clk(Clk), .Rst_n(pRst_n),
        .Light(1'b0), .Sensor(1'b0), .Beeper(1'b0), .lightSwitch(1'b0),
        .finalcarrera1(1'b0), .finalcarrera2(1'b0), .motor1(1'b0), .motor2(1'b0),
        .RxData(8'h00), .RxDone(1'b0), .TxData(pTxData), .TxStart(pTxStart), .TxDone(pTxDone),
        .Busy(pBusy), .TimeoutErr(pTimeoutErr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference CRC-8, byte-at-a-time form
    function automatic logic [7:0] crc8Ref(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] d;
        logic [7:0]  c;
        d = {b0, b1, b2};
        c = 8'h00;
        for (int k = 0; k < 3; k++) begin
            c = c ^ d[23 - 8*k -: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] chkOf(input logic [7:0] st, input logic [7:0] sq, input logic [7:0] hand);
        return CrcOn ? crc8Ref(8'hA5, st, sq) : hand;
    endfunction

    task automatic pushFrame(input logic [7:0] st, input logic [7:0] sq, input logic [7:0] hand);
        expQ.push_back(8'hA5);
        expQ.push_back(st);
        expQ.push_back(sq);
        expQ.push_back(chkOf(st, sq, hand));
    endtask

    task automatic sendQuery();
        RxData = 8'h3F;
        RxDone = 1'b1;
        @(negedge Clk);
        RxDone = 1'b0;
    endtask

    task automatic waitStart(input string name, input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge Clk);
            if (TxStart === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_start actual=no TxStart within %0d cycles expected=TxStart", name, bound);
    endtask

    task automatic waitDrained(input string name, input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge Clk);
            if (expQ.size() == 0 && Busy === 1'b0) begin
                check({name, "_idle"}, Busy, 0);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_drain actual=%0d bytes left busy=%b expected=0 bytes idle", name, expQ.size(), Busy);
    endtask

    // Main scoreboard monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && TxStart === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx actual=%0h expected=no frame", TxData);
                end else begin
                    e = expQ.pop_front();
                    check("tx_byte", TxData, e);
                end
            end
        end
    end

    // Periodic-instance monitor: bytes from its queue plus start-to-start spacing
    initial begin
        logic [7:0] e;
        int pPos = 0, pFrame = 0, pLast = 0;
        forever begin
            @(negedge Clk);
            if (pRst_n === 1'b1 && pTxStart === 1'b1) begin
                if (pPos == 0) begin
                    if (pFrame > 0) check("per_interval", cyc - pLast, 100);
                    pLast = cyc;
                    pFrame++;
                end
                if (pExpQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL per_unexpected actual=%0h expected=no frame", pTxData);
                end else begin
                    e = pExpQ.pop_front();
                    check("per_byte", pTxData, e);
                end
                pPos = (pPos + 1) % 4;
            end
        end
    end

    // UART model for the main instance: TxDone two cycles after each TxStart while budget lasts
    initial begin
        int doneDelay = 0;
        TxDone = 1'b0;
        forever begin
            @(negedge Clk);
            TxDone = 1'b0;
            if (doneDelay > 0) begin
                doneDelay--;
                if (doneDelay == 0) TxDone = 1'b1;
            end
            if (TxStart === 1'b1 && doneBudget > 0) begin
                doneBudget--;
                doneDelay = 2;
            end
        end
    end

    initial begin
        pTxDone = 1'b0;
        pPrev   = 1'b0;
        forever begin
            @(negedge Clk);
            pTxDone = pPrev;
            pPrev   = pTxStart;
        end
    end

    initial begin
        int n;
        Rst_n = 1'b0; pRst_n = 1'b0;
        status = 8'h00; RxData = 8'h00; RxDone = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_txstart", TxStart, 0);
        check("rst_busy", Busy, 0);
        check("rst_timeout", TimeoutErr, 0);
        check("rst_txdata", TxData, 0);
        Rst_n = 1'b1; pRst_n = 1'b1;
        for (int f = 0; f < 258; f++) begin
            pExpQ.push_back(8'hA5);
            pExpQ.push_back(8'h00);
            pExpQ.push_back(f[7:0]);
            pExpQ.push_back(chkOf(8'h00, f[7:0], 8'hA5 ^ f[7:0]));
        end
        repeat (5) @(negedge Clk);
        check("idle_busy", Busy, 0);

        // Query: TxStart two cycles after the RxDone cycle
        status = 8'h01;
        @(negedge Clk);
        pushFrame(8'h01, 8'h00, 8'hA4);
        sendQuery();
        check("q_lat1", TxStart, 0);
        @(negedge Clk);
        check("q_lat2", TxStart, 1);
        check("q_busy", Busy, 1);
        waitDrained("query", 100);

        // Change trigger
        status = 8'h11;
        pushFrame(8'h11, 8'h01, 8'hB5);
        waitStart("chg", 6);
        waitDrained("chg", 100);

        // Coalescing: two queries + status change during a frame -> one follow-up
        repeat (3) @(negedge Clk);
        pushFrame(8'h11, 8'h02, 8'hB6);
        sendQuery();
        waitStart("coal", 4);
        sendQuery();
        status = 8'h13;
        sendQuery();
        pushFrame(8'h13, 8'h03, 8'hB5);
        waitDrained("coal", 200);
        repeat (30) @(negedge Clk);
        check("coal_quiet", Busy, 0);

        // Timeout: second byte never acknowledged
        doneBudget = 1;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h13);
        sendQuery();
        waitStart("to_b0", 4);
        waitStart("to_b1", 10);
        n = 0;
        while (n < 100) begin
            @(negedge Clk);
            n++;
            if (TimeoutErr === 1'b1) break;
        end
        check("to_cycles", n, 51);
        check("to_busy", Busy, 0);
        @(negedge Clk);
        check("to_pulse", TimeoutErr, 0);
        check("to_drained", expQ.size(), 0);
        doneBudget = 1000000;
        repeat (2) @(negedge Clk);
        pushFrame(8'h13, 8'h04, 8'hB2);
        sendQuery();
        waitDrained("resend", 100);

        // Reset in WAIT_DONE
        expQ.push_back(8'hA5);
        sendQuery();
        waitStart("rst_b0", 4);
        @(negedge Clk);
        check("rst_busy_pre", Busy, 1);
        Rst_n = 1'b0;
        status = 8'h01;
        #1;
        check("rst_mid_txstart", TxStart, 0);
        check("rst_mid_busy", Busy, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        pushFrame(8'h01, 8'h00, 8'hA4);
        waitStart("rst_chg", 8);
        waitDrained("rst_chg", 100);

        // Periodic instance: 258 frames covering SEQ wrap
        n = 0;
        while (pExpQ.size() != 0 && n < 40000) begin
            @(negedge Clk);
            n++;
        end
        check("per_remaining", pExpQ.size(), 0);
        pRst_n = 1'b0;
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
